nn_layer_seq: RTL
=================

NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16; data width in signed Q8.8 (half = WIDTH/2 fraction bits).
REQ-002 SHALL have parameter N_IN, default 2; inputs per neuron, range 1..16.
REQ-003 SHALL have parameter N_OUT, default 2; neurons per layer, range 1..16.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_data input WIDTH; serial input-vector load, element 0 first.
REQ-007 SHALL have ports coeff_addr output $clog2(N_IN*N_OUT+N_OUT), coeff_data input WIDTH; synchronous coefficient/bias memory with 1-cycle read latency.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_data output WIDTH, out_idx output $clog2(N_OUT); one neuron result per transfer.
REQ-009 SHALL have port busy output 1; high in every state except IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, MAC, EMIT.
REQ-011 IDLE/LOAD: in_ready=1; each in_valid&&in_ready transfer stores in_data into x[k], k=0..N_IN-1; after x[N_IN-1] the FSM SHALL enter MAC with neuron j=0 (IDLE goes straight to MAC when N_IN=1).
REQ-012 MAC for neuron j SHALL clear acc on entry and issue coeff_addr = j*N_IN+i for i=0..N_IN-1, then bias address N_IN*N_OUT+j, one address per cycle.
REQ-013 Each returned word SHALL be accumulated one cycle after its address: weight terms add mul(x[i],coeff_data), the bias term adds coeff_data directly.
REQ-014 mul(a,b) SHALL be the signed 2*WIDTH product sliced to bits [WIDTH+half-1:half] (truncation, no rounding).
REQ-015 MAC SHALL last exactly N_IN+2 cycles, then enter EMIT.
REQ-016 EMIT: out_valid=1, out_idx=j, out_data = 1<<half (1.0) if acc!=0 and acc MSB=0, else 0.
REQ-017 out_data/out_idx SHALL hold stable while out_valid && !out_ready.
REQ-018 On out_ready in EMIT: j<N_OUT-1 -> MAC with j+1; j=N_OUT-1 -> IDLE.
REQ-019 in_ready SHALL be 0 in MAC and EMIT; in_valid is ignored there.
REQ-020 Latency from last input accept to first out_valid SHALL be N_IN+2 cycles.
REQ-021 Without saturation, accumulation SHALL wrap modulo 2^WIDTH.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, clear acc, x[], j, k, and drive in_ready=0, out_valid=0, out_data=0, out_idx=0, coeff_addr=0, busy=0.
REQ-023 in_ready SHALL rise the first clock after rst_n deasserts; reset mid-MAC/EMIT SHALL drop the partial result with no output.

Configuration
REQ-024 NN_LAYER_SEQ_SAT_EN defined: each accumulate SHALL clamp to 0x7FFF / 0x8000 (WIDTH-scaled) on signed overflow.
REQ-025 NN_LAYER_SEQ_SAT_EN undefined: accumulate wraps (REQ-021); no clamp logic synthesised.

Structure
REQ-026 Package nn_pkg SHALL hold the FSM state enum, the Q-format constants (half, ONE = 1<<half), and the saturating-add function.
REQ-027 Multiply SHALL be a sub-module nn_mul_q (REQ-014 slice), instantiated once and time-shared by all neurons.

Verification
REQ-028 x={0x0100,0x0100}; n0 coeff {0x0100,0x0100}, bias 0xFF00 -> out_idx 0, out_data 0x0100.
REQ-029 Same x; n1 coeff {0x0080,0x0080}, bias 0xFF00 -> acc=0 -> out_data 0x0000 (zero boundary).
REQ-030 out_ready low for 5 cycles in EMIT -> out_valid, out_data, out_idx held unchanged; then advance to n1.
REQ-031 x={0x3000,0x3000}, coeff {0x0200,0x0200}, bias 0 -> with SAT_EN acc=0x7FFF, out 0x0100; without, acc=0xC000, out 0x0000.
REQ-032 rst_n pulsed low in MAC cycle 2 -> outputs zero immediately; no out_valid; next full vector produces correct n0 result.
REQ-033 in_valid held high through MAC/EMIT -> no extra x[] writes; in_ready=0 until IDLE.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - FSM state type, Q-format constants and saturating add shared by nn_layer_seq
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_EMIT = 2'd3
    } nn_state_e;

    localparam int NN_WIDTH = 16;
    localparam int NN_HALF  = NN_WIDTH / 2;
    localparam logic [NN_WIDTH-1:0] NN_ONE = NN_WIDTH'(1) << NN_HALF;

    function automatic int q_half(input int w);
        return w / 2;
    endfunction

    // Operands arrive sign-extended from w bits, so the 32-bit sum cannot itself overflow.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/nn_mul_q.sv
// rtl/nn_mul_q.sv - signed fixed-point multiply, full product truncated back to the input Q-format
module nn_mul_q
    import nn_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    localparam int HALF = q_half(WIDTH);

    logic signed [2*WIDTH-1:0] full;

    assign full = a * b;
    assign p    = WIDTH'(full >>> HALF);

endmodule

// File: rtl/nn_layer_seq.sv
// rtl/nn_layer_seq.sv - sequential fully-connected layer with step activation; NN_LAYER_SEQ_SAT_EN enables saturating accumulate
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
)
(
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [WIDTH-1:0]                         in_data,
    output logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]      coeff_addr,
    input  logic [WIDTH-1:0]                         coeff_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [WIDTH-1:0]                         out_data,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] out_idx,
    output logic                                     busy
);

    localparam int HALF = q_half(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << HALF;
    localparam int AW   = $clog2(N_IN*N_OUT+N_OUT);
    localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW   = $clog2(N_IN + 2);

    nn_state_e               state_q, state_d;
    logic [WIDTH-1:0]        x_q [N_IN];
    logic [WIDTH-1:0]        x_d [N_IN];
    logic [KW-1:0]           k_q, k_d;
    logic [JW-1:0]           j_q, j_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic                    rdy_q, rdy_d;

    logic [KW-1:0]           x_idx;
    logic signed [WIDTH-1:0] mul_a;
    logic signed [WIDTH-1:0] mul_p;
    logic signed [WIDTH-1:0] term;
    logic signed [WIDTH-1:0] acc_sum;
    logic                    is_bias;

    // MAC cycle cnt consumes the word addressed in cycle cnt-1.
    assign x_idx   = KW'(cnt_q - CW'(1));
    assign mul_a   = x_q[x_idx];
    assign is_bias = (cnt_q == CW'(N_IN + 1));

    nn_mul_q #(.WIDTH(WIDTH)) u_mul (
        .a (mul_a),
        .b (coeff_data),
        .p (mul_p)
    );

    assign term = is_bias ? coeff_data : mul_p;

`ifdef NN_LAYER_SEQ_SAT_EN
    assign acc_sum = WIDTH'(sat_add(32'(acc_q), 32'(term), WIDTH));
`else
    assign acc_sum = acc_q + term;
`endif

    always_comb begin
        coeff_addr = '0;
        if (state_q == ST_MAC) begin
            if (cnt_q < CW'(N_IN)) begin
                coeff_addr = AW'(32'(j_q) * 32'(N_IN) + 32'(cnt_q));
            end else if (cnt_q == CW'(N_IN)) begin
                coeff_addr = AW'(32'(N_IN * N_OUT) + 32'(j_q));
            end
        end
    end

    assign in_ready  = rdy_q && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_EMIT);
    assign out_idx   = out_valid ? j_q : '0;
    assign out_data  = (out_valid && (acc_q != '0) && !acc_q[WIDTH-1]) ? ONE : '0;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        k_d     = k_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rdy_d   = 1'b1;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_valid && in_ready) begin
                    x_d[k_q] = in_data;
                    if (k_q == KW'(N_IN - 1)) begin
                        k_d     = '0;
                        j_d     = '0;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_MAC: begin
                if (cnt_q != '0) begin
                    acc_d = acc_sum;
                end
                if (is_bias) begin
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (j_q == JW'(N_OUT - 1)) begin
                        j_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = ST_MAC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < N_IN; i++) begin
                x_q[i] <= '0;
            end
            k_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            k_q     <= k_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule
